// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a per-layer config table and drives the
// neuron FSM (counter loads, clear pulse, run enable) for each neuron.
module layer_sequencer #(
  parameter int N_LAYERS = 4,
  parameter int LW       = $clog2(N_LAYERS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  input  logic          abort,
  input  logic          cfg_we,
  input  logic [LW-1:0] cfg_addr,
  input  logic [23:0]   cfg_data,
  input  logic          fsm_done,
  output logic [7:0]    DB,
  output logic [7:0]    DD,
  output logic          EN_FSM,
  output logic          fsm_clr,
  output logic [LW-1:0] layer_idx,
  output logic [7:0]    neuron_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_RUN,
    S_NEXT,
    S_FIN,
    S_ABRT
  } state_t;

  state_t          state_q, state_d;
  logic [23:0]     cfg_q [N_LAYERS];
  logic [23:0]     cfg_d [N_LAYERS];
  logic [7:0]      db_q, db_d;
  logic [7:0]      dd_q, dd_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      nidx_q, nidx_d;
  logic [LW-1:0]   lidx_q, lidx_d;
  logic            err_q, err_d;

  logic [23:0]     entry;
  logic            skip;
  logic            last_neuron;
  logic            last_layer;
  logic            abort_take;

  assign entry       = cfg_q[lidx_q];
  assign skip        = (entry[23:16] == 8'd0) || (entry[15:0] == 16'd0);
  assign last_neuron = (nidx_q == cnt_q - 8'd1);
  assign last_layer  = (lidx_q == LW'(N_LAYERS - 1));
  // The abort cycle itself always falls back to IDLE, so abort is not
  // re-taken there.
  assign abort_take  = abort && (state_q != S_IDLE) && (state_q != S_ABRT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a low enable freezes the machine
  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        S_IDLE: if (start) state_d = S_LOAD;
        S_LOAD: state_d = skip ? S_NEXT : S_CLR;
        S_CLR:  state_d = S_RUN;
        S_RUN: begin
          if (fsm_done) state_d = last_neuron ? S_NEXT : S_CLR;
        end
        S_NEXT: state_d = last_layer ? S_FIN : S_LOAD;
        S_FIN:  state_d = S_IDLE;
        S_ABRT: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (abort_take) state_d = S_ABRT;
    end
  end

  // Moore output decode; reset clears the state so these drop at once
  always_comb begin
    EN_FSM  = 1'b0;
    fsm_clr = 1'b0;
    done    = 1'b0;
    busy    = (state_q != S_IDLE);
    unique case (1'b1)
      (state_q == S_RUN):  EN_FSM  = 1'b1;
      (state_q == S_CLR):  fsm_clr = 1'b1;
      (state_q == S_ABRT): fsm_clr = 1'b1;
      (state_q == S_FIN):  done    = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: config table, layer/neuron position, err
  always_comb begin
    cfg_d  = cfg_q;
    db_d   = db_q;
    dd_d   = dd_q;
    cnt_d  = cnt_q;
    nidx_d = nidx_q;
    lidx_d = lidx_q;
    err_d  = err_q;
    if (enable) begin
      if (cfg_we) begin
        if (state_q == S_IDLE) cfg_d[cfg_addr] = cfg_data;
        else                   err_d = 1'b1;
      end
      if (!abort_take) begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              lidx_d = '0;
              err_d  = 1'b0;
            end
          end
          S_LOAD: begin
            cnt_d  = entry[23:16];
            db_d   = entry[15:8];
            dd_d   = entry[7:0];
            nidx_d = 8'd0;
          end
          S_RUN: begin
            if (fsm_done && !last_neuron) nidx_d = nidx_q + 8'd1;
          end
          S_NEXT: begin
            if (!last_layer) lidx_d = lidx_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_LAYERS; i++) cfg_q[i] <= '0;
      db_q   <= '0;
      dd_q   <= '0;
      cnt_q  <= '0;
      nidx_q <= '0;
      lidx_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      db_q   <= db_d;
      dd_q   <= dd_d;
      cnt_q  <= cnt_d;
      nidx_q <= nidx_d;
      lidx_q <= lidx_d;
      err_q  <= err_d;
    end
  end

  assign DB         = db_q;
  assign DD         = dd_q;
  assign layer_idx  = lidx_q;
  assign neuron_idx = nidx_q;
  assign err        = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: basic pass, skips, abort,
// write-while-busy, stall, 255-neuron boundary and async reset.
module tb_layer_sequencer;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          reset, enable, start, abort, cfg_we, fsm_done;
  logic [LW-1:0] cfg_addr;
  logic [23:0]   cfg_data;
  logic [7:0]    DB, DD, neuron_idx;
  logic          EN_FSM, fsm_clr, busy, done, err;
  logic [LW-1:0] layer_idx;

  int n_chk, n_pass;
  int clr_cnt, done_cnt, en_rise;
  logic en_prev = 1'b0;
  int c0, d0, e0;
  logic [LW-1:0] li;
  logic [7:0] ni, db, dd;

  layer_sequencer #(.N_LAYERS(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .abort(abort), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .fsm_done(fsm_done), .DB(DB), .DD(DD),
    .EN_FSM(EN_FSM), .fsm_clr(fsm_clr), .layer_idx(layer_idx),
    .neuron_idx(neuron_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (fsm_clr) clr_cnt++;
    if (done) done_cnt++;
    if (EN_FSM && !en_prev) en_rise++;
    en_prev = EN_FSM;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, want);
  endtask

  task automatic cfg_write(input logic [LW-1:0] a, input logic [23:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_en();
    int k = 0;
    while (!EN_FSM && k < 30) begin step(); k++; end
    if (!EN_FSM) chk("en_timeout", {31'd0, EN_FSM}, 32'd1);
  endtask

  // Stand-in neuron FSM: done pulse lat cycles after EN_FSM rises
  task automatic neuron(input int lat, output logic [LW-1:0] l,
                        output logic [7:0] n, output logic [7:0] b,
                        output logic [7:0] d);
    wait_en();
    l = layer_idx; n = neuron_idx; b = DB; d = DD;
    for (int j = 1; j < lat; j++) step();
    fsm_done = 1'b1;
    step();
    fsm_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 100) begin step(); k++; end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; fsm_done = 1'b0;
    #12;
    chk("rst_db_dd", {DB, DD}, 0);
    chk("rst_idx", {layer_idx, neuron_idx}, 0);
    chk("rst_ctl", {EN_FSM, fsm_clr, busy, done, err}, 0);
    reset = 1'b0;
    step();

    // Basic pass: 2 neurons per layer, DB=0 DD=3
    for (int a = 0; a < 4; a++) cfg_write(LW'(a), 24'h020003);
    c0 = clr_cnt; d0 = done_cnt;
    kick();
    chk("lat_load", {busy, fsm_clr, EN_FSM}, 3'b100);
    step();
    chk("lat_clr", {busy, fsm_clr, EN_FSM}, 3'b110);
    step();
    chk("lat_run", {busy, fsm_clr, EN_FSM}, 3'b101);
    for (int i = 0; i < 8; i++) begin
      neuron(5, li, ni, db, dd);
      chk("basic_pos", {li, ni}, {LW'(i / 2), 8'(i % 2)});
      if (i == 0) chk("basic_dbdd", {db, dd}, 16'h0003);
    end
    wait_idle("basic_idle");
    chk("basic_clr", clr_cnt - c0, 8);
    chk("basic_done", done_cnt - d0, 1);
    chk("basic_err", {31'd0, err}, 0);

    // Skip layers 1 (no neurons) and 2 (zero loads)
    cfg_write(0, 24'h011234);
    cfg_write(1, 24'h005566);
    cfg_write(2, 24'h030000);
    cfg_write(3, 24'h01ABCD);
    c0 = clr_cnt; d0 = done_cnt; e0 = en_rise;
    kick();
    neuron(1, li, ni, db, dd);
    chk("skip_l0", {li, ni, db, dd}, {2'd0, 8'd0, 16'h1234});
    neuron(1, li, ni, db, dd);
    chk("skip_l3", {li, ni, db, dd}, {2'd3, 8'd0, 16'hABCD});
    wait_idle("skip_idle");
    chk("skip_clr", clr_cnt - c0, 2);
    chk("skip_en", en_rise - e0, 2);
    chk("skip_done", done_cnt - d0, 1);

    // Start ignored and config write rejected while busy
    for (int a = 0; a < 4; a++) cfg_write(LW'(a), 24'h020003);
    kick();
    wait_en();
    kick();
    chk("start_busy", {EN_FSM, err}, 2'b10);
    cfg_write(3, 24'h01FFEE);
    chk("we_busy_err", {31'd0, err}, 1);
    for (int i = 0; i < 8; i++) begin
      neuron(2, li, ni, db, dd);
      if (i >= 6) chk("we_busy_keep", {li, db, dd}, {2'd3, 16'h0003});
    end
    wait_idle("we_idle");
    chk("err_sticky", {31'd0, err}, 1);

    // Stall in RUN with a done pulse that must be ignored
    c0 = clr_cnt; d0 = done_cnt;
    kick();
    chk("err_clear", {31'd0, err}, 0);
    wait_en();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fsm_done = (i == 3);
      step();
      chk("stall", {EN_FSM, fsm_clr, busy, layer_idx, neuron_idx},
          {1'b1, 1'b0, 1'b1, 2'd0, 8'd0});
    end
    fsm_done = 1'b0;
    enable = 1'b1;
    step();
    chk("stall_after", {EN_FSM, layer_idx, neuron_idx}, 11'h400);
    for (int i = 0; i < 8; i++) neuron(2, li, ni, db, dd);
    wait_idle("stall_idle");
    chk("stall_clr", clr_cnt - c0, 8);
    chk("stall_done", done_cnt - d0, 1);

    // Abort in layer 2 RUN, colliding with fsm_done
    d0 = done_cnt;
    kick();
    for (int i = 0; i < 4; i++) neuron(2, li, ni, db, dd);
    wait_en();
    chk("abort_layer", {30'd0, layer_idx}, 2);
    c0 = clr_cnt;
    abort = 1'b1; fsm_done = 1'b1;
    step();
    abort = 1'b0; fsm_done = 1'b0;
    chk("abort_cyc", {fsm_clr, EN_FSM, busy}, 3'b101);
    step();
    chk("abort_idle", {fsm_clr, EN_FSM, busy}, 3'b000);
    step(); step(); step();
    chk("abort_clr", clr_cnt - c0, 1);
    chk("abort_done", done_cnt - d0, 0);

    // 255 neurons in one layer: last index is 254
    cfg_write(0, 24'hFF0101);
    for (int a = 1; a < 4; a++) cfg_write(LW'(a), 24'h000000);
    c0 = clr_cnt; d0 = done_cnt;
    kick();
    for (int i = 0; i < 255; i++) begin
      neuron(1, li, ni, db, dd);
      if (i == 0) chk("n255_first", {24'd0, ni}, 0);
      if (i == 254) chk("n255_last", {24'd0, ni}, 254);
    end
    wait_idle("n255_idle");
    chk("n255_clr", clr_cnt - c0, 255);
    chk("n255_done", done_cnt - d0, 1);

    // Asynchronous reset between clock edges in RUN
    d0 = done_cnt;
    kick();
    wait_en();
    #3;
    reset = 1'b1;
    #1;
    chk("arst_ctl", {EN_FSM, busy, fsm_clr, err}, 0);
    chk("arst_dbdd", {DB, DD}, 0);
    #2;
    reset = 1'b0;
    step();
    c0 = clr_cnt;
    kick();
    wait_idle("arst_idle");
    chk("arst_cfg_zero", clr_cnt - c0, 0);
    chk("arst_done", done_cnt - d0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
